pulse_train_generator: RTL and testbench

Registered waveform source that produces clean falling edges for the team's edge-detector receivers. On a one-cycle start request it drives signal_out through N pulses with programmable high and low widths, then reports completion. It also raises a falling-edge strobe, so benches and monitors can cross-check a downstream negative edge detector, which fires one cycle later.

---
 rtl/ptg_pkg.sv | 14 +
 rtl/pulse_train_generator_phase_counter.sv | 42 ++++
 rtl/pulse_train_generator.sv | 150 +++++++++++++++
 tb/tb_pulse_train_generator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ptg_pkg.sv
// Shared types and constants for the pulse train generator.
package ptg_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int NUM_W_DEF = 8;
    localparam int MIN_PHASE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_e;

endpackage

// File: rtl/pulse_train_generator_phase_counter.sv
// Loadable up-counter shared by the high and low phases.
module phase_counter
    import ptg_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = W'(MIN_PHASE);
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    // Phase ends in the cycle the count equals the latched width.
    assign tc_o    = (cnt_q == limit_i);

endmodule

// File: rtl/pulse_train_generator.sv
// Generates N registered pulses with programmable high/low widths,
// plus a done strobe and a falling-edge strobe.
module pulse_train_generator
    import ptg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] pulse_count,
    input  logic             abort,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic             fall_strobe
);

    state_e state_q, state_d;

    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [NUM_W-1:0] pcnt_q, pcnt_d;

    logic sig_q, sig_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic fall_q, fall_d;

    logic             ph_load;
    logic             ph_clr;
    logic             ph_en;
    logic [CNT_W-1:0] ph_limit;
    logic [CNT_W-1:0] ph_count;
    logic             ph_tc;

    assign ph_limit = (state_q == S_HIGH) ? hi_q : lo_q;

    phase_counter #(
        .W(CNT_W)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ph_load),
        .clr_i   (ph_clr),
        .en_i    (ph_en),
        .limit_i (ph_limit),
        .count_o (ph_count),
        .tc_o    (ph_tc)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        ph_load = 1'b0;
        ph_clr  = 1'b0;
        ph_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    hi_d = (high_cycles == '0) ? CNT_W'(MIN_PHASE)
                                               : high_cycles;
                    lo_d = (low_cycles == '0) ? CNT_W'(MIN_PHASE)
                                              : low_cycles;
                    if (pulse_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                        pcnt_d  = pulse_count;
                        ph_load = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                    ph_clr  = 1'b1;
                end else if (ph_tc) begin
                    state_d = S_LOW;
                    ph_load = 1'b1;
                end else begin
                    ph_en = 1'b1;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pcnt_d  = '0;
                    ph_clr  = 1'b1;
                end else if (ph_tc) begin
                    if (pcnt_q <= NUM_W'(1)) begin
                        state_d = S_IDLE;
                        pcnt_d  = '0;
                        done_d  = 1'b1;
                        ph_clr  = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                        pcnt_d  = pcnt_q - NUM_W'(1);
                        ph_load = 1'b1;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ph_clr  = 1'b1;
            end
        endcase
        // Outputs are a registered image of the next state.
        sig_d  = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
        fall_d = sig_q && !sig_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            pcnt_q  <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pcnt_q  <= pcnt_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fall_q  <= fall_d;
        end
    end

    assign signal_out  = sig_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fall_strobe = fall_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator with an edge-detector loopback.
module tb_pulse_train_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] high_cycles;
    logic [15:0] low_cycles;
    logic [7:0]  pulse_count;
    logic        abort;
    logic        signal_out;
    logic        busy;
    logic        done;
    logic        fall_strobe;

    int checks = 0;
    int errors = 0;

    logic [15:0] pk_h;
    logic [15:0] pk_l;
    logic [7:0]  pk_n;

    logic prev_q, edge_q, fall_d1;

    pulse_train_generator #(
        .CNT_W(16),
        .NUM_W(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_count (pulse_count),
        .abort       (abort),
        .signal_out  (signal_out),
        .busy        (busy),
        .done        (done),
        .fall_strobe (fall_strobe)
    );

    always #5 clk = ~clk;

    // Downstream negative edge detector plus delayed strobe.
    always @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            fall_d1 <= 1'b0;
        end else begin
            prev_q  <= signal_out;
            edge_q  <= prev_q & ~signal_out;
            fall_d1 <= fall_strobe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic s, input logic f,
                        input logic b, input logic d);
        chk({tag, "_sig"}, signal_out, s);
        chk({tag, "_fall"}, fall_strobe, f);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_done"}, done, d);
    endtask

    // Bits are listed first-cycle-first (MSB side).
    task automatic run(input string tag, input int n, input int poke,
                       input logic [31:0] es, input logic [31:0] ef,
                       input logic [31:0] eb, input logic [31:0] ed);
        for (int i = 0; i < n; i++) begin
            tick();
            outs($sformatf("%s%0d", tag, i), es[n-1-i], ef[n-1-i],
                 eb[n-1-i], ed[n-1-i]);
            if (i == poke) begin
                start       = 1'b1;
                high_cycles = pk_h;
                low_cycles  = pk_l;
                pulse_count = pk_n;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic go(input int h, input int l, input int n);
        high_cycles = 16'(h);
        low_cycles  = 16'(l);
        pulse_count = 8'(n);
        start       = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
        pulse_count = '0;
        pk_h        = '0;
        pk_l        = '0;
        pk_n        = '0;
        tick();
        tick();
        outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        go(3, 2, 2);
        run("basic", 12, -1,
            32'b111001110000, 32'b000100001000,
            32'b111111111100, 32'b000000000010);

        go(5, 5, 0);
        run("n0", 3, -1, 32'b000, 32'b000, 32'b000, 32'b100);

        go(0, 0, 3);
        run("w0", 8, -1,
            32'b10101000, 32'b01010100,
            32'b11111100, 32'b00000010);

        go(5, 5, 4);
        for (int i = 0; i < 11; i++) begin
            tick();
            start = 1'b0;
        end
        chk("abh_pre_sig", signal_out, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        outs("abh", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            outs($sformatf("abh_after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        go(5, 5, 4);
        for (int i = 0; i < 7; i++) begin
            tick();
            start = 1'b0;
        end
        chk("abl_pre_sig", signal_out, 1'b0);
        chk("abl_pre_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        outs("abl", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        outs("abl_after", 1'b0, 1'b0, 1'b0, 1'b0);

        pk_h = 16'd1;
        pk_l = 16'd1;
        pk_n = 8'd1;
        go(3, 2, 2);
        run("busy_start", 12, 1,
            32'b111001110000, 32'b000100001000,
            32'b111111111100, 32'b000000000010);

        go(1, 1, 1);
        run("b2b", 7, 2,
            32'b1001000, 32'b0100100,
            32'b1101100, 32'b0010010);

        go(2, 2, 2);
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        outs("sa", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        outs("sa2", 1'b0, 1'b0, 1'b0, 1'b0);

        go(3, 2, 2);
        tick();
        start = 1'b0;
        tick();
        chk("rst_pre_sig", signal_out, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
        go(3, 2, 2);
        run("post_rst", 12, -1,
            32'b111001110000, 32'b000100001000,
            32'b111111111100, 32'b000000000010);

        for (int tr = 0; tr < 1000; tr++) begin
            int  ab_at;
            bit  fin;
            fin   = 1'b0;
            ab_at = int'($urandom_range(0, 30));
            go(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
            tick();
            start = 1'b0;
            for (int c = 0; c < 40 && !fin; c++) begin
                chk("loop_edge", edge_q, fall_d1);
                if (!busy) begin
                    fin = 1'b1;
                end else begin
                    abort = (c == ab_at);
                    tick();
                end
            end
            abort = 1'b0;
            chk("loop_timeout", fin, 1'b1);
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("loop_tail", edge_q, fall_d1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
